// File: rtl/ldst_stream_port_if.sv
// Bus bundle for the byte-stream port: sequencer I/O strobes plus the
// external TX/RX valid/ready streams. "slave" is the peripheral's view,
// "master" is the view of whatever drives the sequencer and the streams.
interface ldst_stream_port_if;
  logic       clock_enable;
  logic [7:0] io_bus_address;
  logic [7:0] io_bus_data_out;
  logic       io_bus_out;
  logic       io_bus_in;
  logic [7:0] io_bus_data_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport slave (
    input  clock_enable, io_bus_address, io_bus_data_out, io_bus_out, io_bus_in,
    input  tx_ready, rx_data, rx_valid,
    output io_bus_data_in, tx_data, tx_valid, rx_ready
  );

  modport master (
    output clock_enable, io_bus_address, io_bus_data_out, io_bus_out, io_bus_in,
    output tx_ready, rx_data, rx_valid,
    input  io_bus_data_in, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/ldst_stream_port.sv
// Byte-stream I/O peripheral: TX FIFO fed by sequencer stores to DATA and
// drained by a valid/ready stream, RX FIFO filled by a valid/ready stream and
// drained by sequencer loads from DATA. STATUS holds sticky error flags (W1C),
// COUNT reports both fill levels. Read data is zero when unselected so several
// peripherals can be OR-merged onto the sequencer's read bus.
module ldst_stream_port #(
  parameter logic [7:0] BASE_ADDRESS = 8'h10,
  parameter int         FIFO_DEPTH   = 4
) (
  input logic                clock,
  input logic                reset,
  ldst_stream_port_if.slave  bus
);

  localparam int         PTR_W       = (FIFO_DEPTH == 2) ? 1 : (FIFO_DEPTH == 4) ? 2 : 3;
  localparam logic [3:0] DEPTH_CNT   = 4'(FIFO_DEPTH);
  localparam logic [7:0] DATA_ADDR   = BASE_ADDRESS;
  localparam logic [7:0] STATUS_ADDR = BASE_ADDRESS + 8'd1;
  localparam logic [7:0] COUNT_ADDR  = BASE_ADDRESS + 8'd2;

  // Reject configurations the pointer/count widths are not sized for, and
  // addresses that would collide with the sequencer's internal range.
  generate
    if (!(FIFO_DEPTH == 2 || FIFO_DEPTH == 4 || FIFO_DEPTH == 8) ||
        BASE_ADDRESS < 8'h04 || BASE_ADDRESS > 8'hFD) begin : g_bad_param
      $error("ldst_stream_port: illegal BASE_ADDRESS or FIFO_DEPTH");
    end
  endgenerate

  // FIFO storage and state
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_rd_ptr_reg, tx_wr_ptr_reg;
  logic [PTR_W-1:0] rx_rd_ptr_reg, rx_wr_ptr_reg;
  logic [3:0]       tx_count_reg, rx_count_reg;
  logic             tx_drop_reg, rx_underflow_reg;

  // Decoded status
  logic tx_empty, tx_full, rx_nonempty, rx_full;
  assign tx_empty    = (tx_count_reg == 4'd0);
  assign tx_full     = (tx_count_reg == DEPTH_CNT);
  assign rx_nonempty = (rx_count_reg != 4'd0);
  assign rx_full     = (rx_count_reg == DEPTH_CNT);

  // Sequencer-side register accesses, all qualified by clock_enable
  logic wr_data, rd_data, wr_status;
  assign wr_data   = bus.clock_enable & bus.io_bus_out & (bus.io_bus_address == DATA_ADDR);
  assign rd_data   = bus.clock_enable & bus.io_bus_in  & (bus.io_bus_address == DATA_ADDR);
  assign wr_status = bus.clock_enable & bus.io_bus_out & (bus.io_bus_address == STATUS_ADDR);

  // Push/pop qualifiers. A push into a full TX is rejected on the pre-edge
  // fullness, so a same-cycle stream pop does not rescue it.
  logic tx_push, tx_pop, rx_push, rx_pop;
  assign tx_push = wr_data & ~tx_full;
  assign tx_pop  = ~tx_empty & bus.tx_ready;
  assign rx_push = bus.rx_valid & bus.rx_ready;
  assign rx_pop  = rd_data & rx_nonempty;

  // Stream-side outputs; rx_ready is forced low while reset is held
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_reg];
  assign bus.rx_ready = reset & ~rx_full;

  // Sticky flags: clear via W1C first, then set, so a same-cycle set wins
  logic tx_drop_next, rx_underflow_next;
  always_comb begin
    tx_drop_next      = tx_drop_reg;
    rx_underflow_next = rx_underflow_reg;
    if (wr_status && bus.io_bus_data_out[4]) tx_drop_next = 1'b0;
    if (wr_status && bus.io_bus_data_out[5]) rx_underflow_next = 1'b0;
    if (wr_data && tx_full)                  tx_drop_next = 1'b1;
    if (rd_data && !rx_nonempty)             rx_underflow_next = 1'b1;
  end

  // Combinational register read, zero when no register is selected
  always_comb begin
    bus.io_bus_data_in = 8'h00;
    if (bus.io_bus_address == DATA_ADDR) begin
      bus.io_bus_data_in = rx_nonempty ? rx_mem[rx_rd_ptr_reg] : 8'h00;
    end else if (bus.io_bus_address == STATUS_ADDR) begin
      bus.io_bus_data_in = {2'b00, rx_underflow_reg, tx_drop_reg,
                            rx_full, tx_empty, tx_full, rx_nonempty};
    end else if (bus.io_bus_address == COUNT_ADDR) begin
      bus.io_bus_data_in = {rx_count_reg, tx_count_reg};
    end
  end

  // FIFO payload storage; contents need no reset since pointers/counts gate them
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.io_bus_data_out;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.rx_data;
  end

  // Pointers, counts and sticky flags; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_rd_ptr_reg    <= '0;
      tx_wr_ptr_reg    <= '0;
      rx_rd_ptr_reg    <= '0;
      rx_wr_ptr_reg    <= '0;
      tx_count_reg     <= 4'd0;
      rx_count_reg     <= 4'd0;
      tx_drop_reg      <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_W'(1);
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_W'(1);
      tx_count_reg     <= tx_count_reg + {3'b000, tx_push} - {3'b000, tx_pop};
      rx_count_reg     <= rx_count_reg + {3'b000, rx_push} - {3'b000, rx_pop};
      tx_drop_reg      <= tx_drop_next;
      rx_underflow_reg <= rx_underflow_next;
    end
  end

endmodule

// File: tb/tb_ldst_stream_port.sv
// Directed bench for ldst_stream_port (BASE=8'h10, DEPTH=4). A queue-based
// model of the two FIFOs and sticky flags is checked against the DUT every
// negative clock edge; literal expectations pin the model at key points.
module tb_ldst_stream_port;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   checking = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ldst_stream_port_if bus_if();

  ldst_stream_port #(.BASE_ADDRESS(8'h10), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_if)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_drop, m_und;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a == 8'h10) r = (m_rx.size() != 0) ? m_rx[0] : 8'h00;
    else if (a == 8'h11)
      r = {2'b00, m_und, m_drop, m_rx.size() == DEPTH, m_tx.size() == 0,
           m_tx.size() == DEPTH, m_rx.size() != 0};
    else if (a == 8'h12) r = {4'(m_rx.size()), 4'(m_tx.size())};
    return r;
  endfunction

  // Model update from the inputs present at each rising edge
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_tx.delete();
      m_rx.delete();
      m_drop = 1'b0;
      m_und  = 1'b0;
    end else begin
      automatic bit wr_d = bus_if.clock_enable && bus_if.io_bus_out && bus_if.io_bus_address == 8'h10;
      automatic bit rd_d = bus_if.clock_enable && bus_if.io_bus_in  && bus_if.io_bus_address == 8'h10;
      automatic bit wr_s = bus_if.clock_enable && bus_if.io_bus_out && bus_if.io_bus_address == 8'h11;
      automatic bit tx_full_pre = (m_tx.size() == DEPTH);
      automatic bit tx_take = (m_tx.size() != 0) && bus_if.tx_ready;
      automatic bit rx_take = bus_if.rx_valid && (m_rx.size() < DEPTH);
      automatic bit rx_give = rd_d && (m_rx.size() != 0);
      automatic logic [7:0] wdata = bus_if.io_bus_data_out;
      automatic logic [7:0] rdata = bus_if.rx_data;
      if (wr_s && wdata[4]) m_drop = 1'b0;
      if (wr_s && wdata[5]) m_und = 1'b0;
      if (wr_d && tx_full_pre) m_drop = 1'b1;
      if (rd_d && m_rx.size() == 0) m_und = 1'b1;
      if (tx_take) void'(m_tx.pop_front());
      if (wr_d && !tx_full_pre) m_tx.push_back(wdata);
      if (rx_give) void'(m_rx.pop_front());
      if (rx_take) m_rx.push_back(rdata);
    end
  end

  // Per-cycle comparison of all DUT outputs against the model
  always @(negedge clock) begin
    if (checking) begin
      if (!reset) begin
        chk("rst_tx_valid", {7'd0, bus_if.tx_valid}, 8'd0);
        chk("rst_tx_data", bus_if.tx_data, 8'h00);
        chk("rst_rx_ready", {7'd0, bus_if.rx_ready}, 8'd0);
      end else begin
        chk("tx_valid", {7'd0, bus_if.tx_valid}, {7'd0, m_tx.size() != 0});
        chk("tx_data", bus_if.tx_data, (m_tx.size() != 0) ? m_tx[0] : 8'h00);
        chk("rx_ready", {7'd0, bus_if.rx_ready}, {7'd0, m_rx.size() < DEPTH});
        chk("io_bus_data_in", bus_if.io_bus_data_in, m_read(bus_if.io_bus_address));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_if.clock_enable = 1'b1;
    bus_if.io_bus_address = a;
    bus_if.io_bus_data_out = d;
    bus_if.io_bus_out = 1'b1;
    cyc();
    bus_if.io_bus_out = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus_if.clock_enable = 1'b1;
    bus_if.io_bus_address = a;
    bus_if.io_bus_in = 1'b1;
    @(negedge clock);
    chk(name, bus_if.io_bus_data_in, exp);
    cyc();
    bus_if.io_bus_in = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus_if.io_bus_address = a;
    @(negedge clock);
    chk(name, bus_if.io_bus_data_in, exp);
    cyc();
  endtask

  logic [7:0] rec_tx[$];
  logic [7:0] rec_rx[$];

  initial begin
    bus_if.clock_enable = 1'b1;
    bus_if.io_bus_address = 8'h00;
    bus_if.io_bus_data_out = 8'h00;
    bus_if.io_bus_out = 1'b0;
    bus_if.io_bus_in = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_data = 8'h00;
    bus_if.rx_valid = 1'b0;
    #1 reset = 1'b0;
    #1 checking = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;

    // Post-reset state
    @(negedge clock);
    chk("init_tx_valid", {7'd0, bus_if.tx_valid}, 8'd0);
    chk("init_rx_ready", {7'd0, bus_if.rx_ready}, 8'd1);
    cyc();
    peek(8'h11, 8'h04, "init_status");
    peek(8'h12, 8'h00, "init_count");

    // TX fill to full with one dropped byte, then drain
    for (int i = 0; i < 5; i++) wr(8'h10, 8'hA1 + 8'(i));
    peek(8'h12, 8'h04, "tx_full_count");
    peek(8'h11, 8'h12, "tx_full_status");
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("tx_drain_data", bus_if.tx_data, 8'hA1 + 8'(i));
      cyc();
    end
    @(negedge clock);
    chk("tx_drain_empty", {7'd0, bus_if.tx_valid}, 8'd0);
    cyc();
    bus_if.tx_ready = 1'b0;

    // RX push, reads, underflow and W1C clear
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data = 8'h55;
    cyc();
    bus_if.rx_data = 8'h66;
    cyc();
    bus_if.rx_valid = 1'b0;
    @(negedge clock);
    chk("rx_ready_two", {7'd0, bus_if.rx_ready}, 8'd1);
    cyc();
    peek(8'h12, 8'h20, "rx_count");
    rd(8'h10, 8'h55, "rx_read0");
    rd(8'h10, 8'h66, "rx_read1");
    rd(8'h10, 8'h00, "rx_read_empty");
    peek(8'h11, 8'h34, "underflow_status");
    wr(8'h11, 8'h30);
    peek(8'h11, 8'h04, "w1c_status");

    // clock_enable low: sequencer strobes ignored, streams still move
    bus_if.tx_ready = 1'b0;
    wr(8'h10, 8'h99);
    bus_if.clock_enable = 1'b0;
    bus_if.io_bus_address = 8'h10;
    bus_if.io_bus_data_out = 8'hEE;
    bus_if.io_bus_out = 1'b1;
    bus_if.io_bus_in = 1'b1;
    bus_if.tx_ready = 1'b1;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data = 8'h77;
    @(negedge clock);
    chk("ce0_tx_data", bus_if.tx_data, 8'h99);
    chk("ce0_read", bus_if.io_bus_data_in, 8'h00);
    cyc();
    bus_if.io_bus_out = 1'b0;
    bus_if.io_bus_in = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.clock_enable = 1'b1;
    peek(8'h12, 8'h10, "ce0_count");
    peek(8'h11, 8'h05, "ce0_status");
    rd(8'h10, 8'h77, "ce0_rx_byte");

    // RX full, then a read frees a slot for the waiting byte
    for (int i = 1; i <= 4; i++) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data = 8'(i);
      cyc();
    end
    bus_if.rx_data = 8'h05;
    bus_if.io_bus_address = 8'h10;
    bus_if.io_bus_in = 1'b1;
    @(negedge clock);
    chk("rx_full_ready", {7'd0, bus_if.rx_ready}, 8'd0);
    chk("rx_full_head", bus_if.io_bus_data_in, 8'h01);
    cyc();
    bus_if.io_bus_in = 1'b0;
    @(negedge clock);
    chk("rx_ready_after_pop", {7'd0, bus_if.rx_ready}, 8'd1);
    cyc();
    bus_if.rx_valid = 1'b0;
    for (int i = 2; i <= 5; i++) rd(8'h10, 8'(i), "rx_full_drain");

    // Ten bytes through TX with pointer wrap
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_if.io_bus_address = 8'h10;
      bus_if.io_bus_data_out = 8'hB0 + 8'(i);
      bus_if.io_bus_out = 1'b1;
      @(negedge clock);
      if (bus_if.tx_valid) rec_tx.push_back(bus_if.tx_data);
      cyc();
    end
    bus_if.io_bus_out = 1'b0;
    @(negedge clock);
    if (bus_if.tx_valid) rec_tx.push_back(bus_if.tx_data);
    cyc();
    chk("tx_stream_len", 8'(rec_tx.size()), 8'd10);
    for (int i = 0; i < 10 && i < rec_tx.size(); i++)
      chk("tx_stream_byte", rec_tx[i], 8'hB0 + 8'(i));
    bus_if.tx_ready = 1'b0;

    // Ten bytes through RX with pointer wrap, read as they arrive
    bus_if.io_bus_address = 8'h10;
    for (int i = 0; i < 10; i++) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data = 8'hC0 + 8'(i);
      bus_if.io_bus_in = (i > 0);
      @(negedge clock);
      if (bus_if.io_bus_in) rec_rx.push_back(bus_if.io_bus_data_in);
      cyc();
    end
    bus_if.rx_valid = 1'b0;
    bus_if.io_bus_in = 1'b1;
    @(negedge clock);
    rec_rx.push_back(bus_if.io_bus_data_in);
    cyc();
    bus_if.io_bus_in = 1'b0;
    chk("rx_stream_len", 8'(rec_rx.size()), 8'd10);
    for (int i = 0; i < 10 && i < rec_rx.size(); i++)
      chk("rx_stream_byte", rec_rx[i], 8'hC0 + 8'(i));

    // Mid-operation reset with TX holding three bytes
    for (int i = 0; i < 3; i++) wr(8'h10, 8'hD0 + 8'(i));
    @(negedge clock);
    chk("pre_rst_tx_valid", {7'd0, bus_if.tx_valid}, 8'd1);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {7'd0, bus_if.tx_valid}, 8'd0);
    chk("mid_rst_tx_data", bus_if.tx_data, 8'h00);
    chk("mid_rst_rx_ready", {7'd0, bus_if.rx_ready}, 8'd0);
    cyc();
    cyc();
    reset = 1'b1;
    peek(8'h12, 8'h00, "post_rst_count");
    peek(8'h11, 8'h04, "post_rst_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
